// File: rtl/serv_dbus_sram_if.sv
// Wishbone-classic data-bus bundle between the SERV load/store path and a responder.
// The requester drives the request fields; the responder returns registered rdt/ack.
interface serv_dbus_sram_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/serv_dbus_sram.sv
// Wishbone-classic SRAM responder for the SERV data bus with a programmable number of
// wait states, byte-lane writes and out-of-range decode that still acknowledges.
module serv_dbus_sram #(
  parameter int          AW   = 8,
  parameter int          WAIT = 1,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input logic             i_clk,
  input logic             i_rst,
  serv_dbus_sram_if.slave wb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam bit         NO_WAIT  = (WAIT == 0);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] req_idx;
  logic          req_hit;
  logic [31:0]   req_dat;
  logic [3:0]    req_sel;
  logic          req_we;
  logic          ack_q;
  logic [31:0]   rdt_q;

  logic [31:0] mem [2**AW];

  logic          in_hit;
  logic          from_idle;
  logic          do_access;
  logic [AW-1:0] acc_idx;
  logic          acc_hit;
  logic [31:0]   acc_dat;
  logic [3:0]    acc_sel;
  logic          acc_we;
  logic          unused;

  assign in_hit = (wb.adr[31:AW+2] == BASE[31:AW+2]);
  assign unused = &{1'b0, wb.adr[1:0]};

  // With zero wait states the access happens on the capture edge itself, so the live
  // request fields are used; otherwise the captured copy is authoritative.
  assign from_idle = (state == S_IDLE) && wb.cyc && NO_WAIT;
  assign do_access = !i_rst && (from_idle || ((state == S_WAIT) && (cnt == 4'd0)));

  assign acc_idx = from_idle ? wb.adr[AW+1:2] : req_idx;
  assign acc_hit = from_idle ? in_hit         : req_hit;
  assign acc_dat = from_idle ? wb.dat         : req_dat;
  assign acc_sel = from_idle ? wb.sel         : req_sel;
  assign acc_we  = from_idle ? wb.we          : req_we;

  assign wb.ack = ack_q;
  assign wb.rdt = rdt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      req_idx <= '0;
      req_hit <= 1'b0;
      req_dat <= 32'h0;
      req_sel <= 4'h0;
      req_we  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= do_access;
      case (state)
        S_IDLE: begin
          if (wb.cyc) begin
            req_idx <= wb.adr[AW+1:2];
            req_hit <= in_hit;
            req_dat <= wb.dat;
            req_sel <= wb.sel;
            req_we  <= wb.we;
            if (NO_WAIT) begin
              state <= S_ACK;
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        // Reaching zero commits to the ack even if cyc has just dropped.
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACK;
          end else if (!wb.cyc) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_access && acc_we && acc_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdt_q <= 32'h0;
    end else if (do_access && !acc_we) begin
      rdt_q <= acc_hit ? mem[acc_idx] : 32'h0;
    end
  end

endmodule

// File: tb/tb_serv_dbus_sram.sv
// Directed bench for serv_dbus_sram: three instances with WAIT = 1, 3 and 0 exercise
// latency, byte lanes, abort, out-of-range decode, back-to-back requests and reset.
module tb_serv_dbus_sram;

  logic clk;
  int   vectors;
  int   miscompares;

  logic [31:0] b_adr [3];
  logic [31:0] b_dat [3];
  logic [3:0]  b_sel [3];
  logic        b_we  [3];
  logic        b_cyc [3];
  logic        b_rst [3];
  logic [31:0] o_rdt [3];
  logic        o_ack [3];

  serv_dbus_sram_if bus_w1 ();
  serv_dbus_sram_if bus_w3 ();
  serv_dbus_sram_if bus_w0 ();

  assign bus_w1.adr = b_adr[0];
  assign bus_w1.dat = b_dat[0];
  assign bus_w1.sel = b_sel[0];
  assign bus_w1.we  = b_we[0];
  assign bus_w1.cyc = b_cyc[0];
  assign o_rdt[0]   = bus_w1.rdt;
  assign o_ack[0]   = bus_w1.ack;

  assign bus_w3.adr = b_adr[1];
  assign bus_w3.dat = b_dat[1];
  assign bus_w3.sel = b_sel[1];
  assign bus_w3.we  = b_we[1];
  assign bus_w3.cyc = b_cyc[1];
  assign o_rdt[1]   = bus_w3.rdt;
  assign o_ack[1]   = bus_w3.ack;

  assign bus_w0.adr = b_adr[2];
  assign bus_w0.dat = b_dat[2];
  assign bus_w0.sel = b_sel[2];
  assign bus_w0.we  = b_we[2];
  assign bus_w0.cyc = b_cyc[2];
  assign o_rdt[2]   = bus_w0.rdt;
  assign o_ack[2]   = bus_w0.ack;

  serv_dbus_sram #(.AW(8), .WAIT(1), .BASE(32'h0)) dut_w1 (.i_clk(clk), .i_rst(b_rst[0]), .wb(bus_w1));
  serv_dbus_sram #(.AW(8), .WAIT(3), .BASE(32'h0)) dut_w3 (.i_clk(clk), .i_rst(b_rst[1]), .wb(bus_w3));
  serv_dbus_sram #(.AW(8), .WAIT(0), .BASE(32'h0)) dut_w0 (.i_clk(clk), .i_rst(b_rst[2]), .wb(bus_w0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full request on instance k, started just after a falling edge; checks the ack
  // latency in clock edges and that ack lasts a single cycle, and returns rdt at ack.
  task automatic applyStimulus(input int k, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic we, input int exp_lat,
                               input string tag, output logic [31:0] rd);
    int n;
    bit seen;
    b_adr[k] = adr;
    b_dat[k] = dat;
    b_sel[k] = sel;
    b_we[k]  = we;
    b_cyc[k] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (o_ack[k] === 1'b1) seen = 1'b1;
    end
    b_cyc[k] = 1'b0;
    rd = o_rdt[k];
    checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
    @(negedge clk);
    checkOutput({tag, " ack width"}, {31'h0, o_ack[k]}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int ack_count;
    vectors = 0;
    miscompares = 0;
    for (int k = 0; k < 3; k++) begin
      b_adr[k] = 32'h0;
      b_dat[k] = 32'h0;
      b_sel[k] = 4'h0;
      b_we[k]  = 1'b0;
      b_cyc[k] = 1'b0;
      b_rst[k] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset ack dut%0d", k), {31'h0, o_ack[k]}, 32'h0);
      checkOutput($sformatf("reset rdt dut%0d", k), o_rdt[k], 32'h0);
      b_rst[k] = 1'b0;
    end
    @(negedge clk);

    $display("[TB] WAIT=1 full-word write and read");
    applyStimulus(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 2, "w1 wr 0x10", rd);
    applyStimulus(0, 32'h10, 32'h0, 4'hF, 1'b0, 2, "w1 rd 0x10", rd);
    checkOutput("w1 rd 0x10 data", rd, 32'hDEADBEEF);

    $display("[TB] WAIT=1 byte lanes");
    applyStimulus(0, 32'h10, 32'h11223344, 4'b0101, 1'b1, 2, "w1 lane wr", rd);
    applyStimulus(0, 32'h10, 32'h0, 4'hF, 1'b0, 2, "w1 lane rd F", rd);
    checkOutput("w1 lane rd F data", rd, 32'hDE22BE44);
    applyStimulus(0, 32'h10, 32'h0, 4'b0001, 1'b0, 2, "w1 lane rd 1", rd);
    checkOutput("w1 lane rd 1 data", rd, 32'hDE22BE44);

    $display("[TB] WAIT=1 out-of-range decode");
    applyStimulus(0, 32'h0, 32'h01234567, 4'hF, 1'b1, 2, "w1 wr 0x0", rd);
    applyStimulus(0, 32'h400, 32'h0, 4'hF, 1'b0, 2, "w1 oor rd", rd);
    checkOutput("w1 oor rd data", rd, 32'h0);
    applyStimulus(0, 32'h400, 32'h55555555, 4'hF, 1'b1, 2, "w1 oor wr", rd);
    applyStimulus(0, 32'h0, 32'h0, 4'hF, 1'b0, 2, "w1 rd 0x0", rd);
    checkOutput("w1 no alias data", rd, 32'h01234567);

    $display("[TB] WAIT=3 abort");
    applyStimulus(1, 32'h20, 32'h0, 4'hF, 1'b1, 4, "w3 wr 0x20", rd);
    b_adr[1] = 32'h20;
    b_dat[1] = 32'hAAAAAAAA;
    b_sel[1] = 4'hF;
    b_we[1]  = 1'b1;
    b_cyc[1] = 1'b1;
    @(negedge clk);
    b_cyc[1] = 1'b0;
    ack_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_ack[1] !== 1'b0) ack_count++;
    end
    checkOutput("w3 abort ack count", 32'(ack_count), 32'h0);
    applyStimulus(1, 32'h20, 32'h0, 4'hF, 1'b0, 4, "w3 rd 0x20", rd);
    checkOutput("w3 abort mem data", rd, 32'h0);

    $display("[TB] WAIT=0 back-to-back reads");
    applyStimulus(2, 32'h0, 32'h0000A0A0, 4'hF, 1'b1, 1, "w0 wr 0x0", rd);
    applyStimulus(2, 32'h4, 32'h0000B4B4, 4'hF, 1'b1, 1, "w0 wr 0x4", rd);
    b_adr[2] = 32'h0;
    b_we[2]  = 1'b0;
    b_sel[2] = 4'hF;
    b_cyc[2] = 1'b1;
    @(negedge clk);
    checkOutput("w0 b2b first ack", {31'h0, o_ack[2]}, 32'h1);
    checkOutput("w0 b2b first data", o_rdt[2], 32'h0000A0A0);
    b_adr[2] = 32'h4;
    @(negedge clk);
    checkOutput("w0 b2b idle gap", {31'h0, o_ack[2]}, 32'h0);
    @(negedge clk);
    checkOutput("w0 b2b second ack", {31'h0, o_ack[2]}, 32'h1);
    checkOutput("w0 b2b second data", o_rdt[2], 32'h0000B4B4);
    b_cyc[2] = 1'b0;
    @(negedge clk);
    checkOutput("w0 b2b trailing ack", {31'h0, o_ack[2]}, 32'h0);

    $display("[TB] WAIT=1 reset mid-transaction");
    applyStimulus(0, 32'h8, 32'h08080808, 4'hF, 1'b1, 2, "w1 wr 0x8", rd);
    applyStimulus(0, 32'h8, 32'h0, 4'hF, 1'b0, 2, "w1 rd 0x8", rd);
    checkOutput("w1 rd 0x8 data", rd, 32'h08080808);
    b_adr[0] = 32'h8;
    b_dat[0] = 32'hFFFFFFFF;
    b_sel[0] = 4'hF;
    b_we[0]  = 1'b1;
    b_cyc[0] = 1'b1;
    @(negedge clk);
    b_rst[0] = 1'b1;
    b_cyc[0] = 1'b0;
    #1;
    checkOutput("rst async ack", {31'h0, o_ack[0]}, 32'h0);
    checkOutput("rst async rdt", o_rdt[0], 32'h0);
    @(negedge clk);
    checkOutput("rst held ack", {31'h0, o_ack[0]}, 32'h0);
    b_rst[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst released ack", {31'h0, o_ack[0]}, 32'h0);
    checkOutput("rst released rdt", o_rdt[0], 32'h0);
    applyStimulus(0, 32'h8, 32'h0, 4'hF, 1'b0, 2, "post-rst rd 0x8", rd);
    checkOutput("post-rst 0x8 unchanged", rd, 32'h08080808);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
